// File: rtl/vec_pkg.sv
// Shared vector-pipeline types: lane geometry, lane-vector type and the
// memory-stage FSM encoding.
package vec_pkg;

    localparam int N = 20;
    localparam int L = 8;

    typedef logic [L-1:0][N-1:0] vec_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LANE = 2'd1,
        S_DONE = 2'd2
    } vmem_state_t;

endpackage

// File: rtl/vec_lane_select.sv
// Combinational L:1 lane mux with a one-hot lane-write decoder on the same
// select, so one lane index drives both the read and the write side.
module vec_lane_select #(
    parameter int W  = 20,
    parameter int L  = 8,
    parameter int SW = $clog2(L)
) (
    input  logic [L-1:0][W-1:0] vec,
    input  logic [SW-1:0]       sel,
    input  logic                wr_en,
    output logic [W-1:0]        lane,
    output logic [L-1:0]        wr_onehot
);

    assign lane = vec[sel];

    for (genvar i = 0; i < L; i++) begin : g_dec
        assign wr_onehot[i] = wr_en && (sel == SW'(i));
    end

endmodule

// File: rtl/vec_mem_access.sv
// Vector memory stage: serializes a gather load or scatter store over a
// single-lane memory port, one lane per transaction, in lane order.
module vec_mem_access #(
    parameter int N  = 20,
    parameter int L  = 8,
    parameter int AW = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                startM,
    input  logic                MemWriteM,
    input  logic [L-1:0]        LaneMaskM,
    input  logic [L-1:0][N-1:0] ALUResultM,
    input  logic [L-1:0][N-1:0] WriteDataM,
    output logic                mem_req,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [N-1:0]        mem_wdata,
    input  logic [N-1:0]        mem_rdata,
    input  logic                mem_ack,
    output logic [L-1:0][N-1:0] ReadDataM,
    output logic                busyM,
    output logic                doneM
);
    import vec_pkg::*;

    localparam int KW = $clog2(L);

    vmem_state_t           state;
    logic [KW-1:0]         k;
    logic                  we_q;
    logic [L-1:0]          mask_q;
    logic [L-1:0][N-1:0]   addr_q;
    logic [L-1:0][N-1:0]   wdata_q;
    logic [L-1:0][2*N-1:0] lane_vec;
    logic [2*N-1:0]        lane_sel;
    logic [L-1:0]          rd_wr;
    logic                  in_lane;
    logic                  advance;

    // Address and store data travel together so one mux serves both.
    for (genvar i = 0; i < L; i++) begin : g_pack
        assign lane_vec[i] = {addr_q[i], wdata_q[i]};
    end

    vec_lane_select #(.W(2*N), .L(L)) u_sel (
        .vec       (lane_vec),
        .sel       (k),
        .wr_en     (mem_req & mem_ack & ~we_q),
        .lane      (lane_sel),
        .wr_onehot (rd_wr)
    );

    // Port outputs decode from registered state only; mem_ack never feeds mem_req.
    assign in_lane   = (state == S_LANE);
    assign mem_req   = in_lane & mask_q[k];
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? lane_sel[N +: AW] : '0;
    assign mem_wdata = mem_req ? lane_sel[N-1:0] : '0;
    assign advance   = ~mask_q[k] | mem_ack;
    assign busyM     = startM | in_lane;
    assign doneM     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            k         <= '0;
            we_q      <= 1'b0;
            mask_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ReadDataM <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (startM) begin
                        we_q      <= MemWriteM;
                        mask_q    <= LaneMaskM;
                        addr_q    <= ALUResultM;
                        wdata_q   <= WriteDataM;
                        k         <= '0;
                        ReadDataM <= '0;
                        state     <= S_LANE;
                    end
                end
                S_LANE: begin
                    for (int i = 0; i < L; i++) begin
                        if (rd_wr[i]) ReadDataM[i] <= mem_rdata;
                    end
                    if (advance) begin
                        if (k == KW'(L-1)) state <= S_DONE;
                        else               k     <= k + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
